// File: rtl/oscillator.sv
// Square-wave tone generator.
// A full period lasts `divider` clk cycles: a high phase of floor(divider/2) cycles
// followed by a low phase of ceil(divider/2) cycles.
// The divider input is sampled only when a tone starts and at each period boundary,
// so every emitted period is complete.
module oscillator #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] divider,
    output logic             square,
    output logic             active,
    output logic             period_end
);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    localparam logic [DIV_W-1:0] MinDiv = DIV_W'(2);
    localparam logic [DIV_W-1:0] One    = DIV_W'(1);

    state_e           state;
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] count;
    logic             div_ok;
    logic             at_end;

    // Divider values of 0 and 1 cannot form a tone.
    // cur_div is at least 2 whenever state is StRun, so cur_div - 1 cannot underflow there.
    always_comb begin
        div_ok = (divider >= MinDiv);
        at_end = (count == (cur_div - One));
    end

    // Tone state machine.
    // A new divider is accepted only on entry from idle or at a period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            cur_div <= '0;
            count   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    count <= '0;
                    if (en && div_ok) begin
                        cur_div <= divider;
                        state   <= StRun;
                    end
                end
                StRun: begin
                    if (!en) begin
                        // Mute at once, without waiting for the end of the period.
                        state <= StIdle;
                        count <= '0;
                    end else if (at_end) begin
                        count <= '0;
                        if (div_ok) begin
                            cur_div <= divider;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        count <= count + One;
                    end
                end
                default: begin
                    state <= StIdle;
                    count <= '0;
                end
            endcase
        end
    end

    // Outputs are decoded from registers only.
    // There is no combinational path from en or divider to any output.
    always_comb begin
        active     = (state == StRun);
        square     = active && (count < (cur_div >> 1));
        period_end = active && at_end;
    end

endmodule

// File: tb/tb_oscillator.sv
// Self-checking bench for oscillator.
// The reference model keeps a queue holding the expected {square, period_end} waveform
// of the period currently being played. A fresh period is queued when a tone starts or
// when the previous period has been fully consumed.
module tb_oscillator;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] divider;
    logic        square;
    logic        active;
    logic        period_end;

    int tests = 0;
    int fails = 0;

    logic [1:0] mq[$];
    logic       m_sq, m_act, m_pe;

    oscillator #(.DIV_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .divider    (divider),
        .square     (square),
        .active     (active),
        .period_end (period_end)
    );

    always #5 clk = ~clk;

    task automatic push_period(input int n);
        for (int i = 0; i < n; i++) mq.push_back({(i < n / 2), (i == n - 1)});
    endtask

    task automatic model_outputs();
        m_act = (mq.size() != 0);
        m_sq  = m_act ? mq[0][1] : 1'b0;
        m_pe  = m_act ? mq[0][0] : 1'b0;
    endtask

    // One clock edge. The model consumes the inputs that were present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else if (mq.size() != 0) begin
            if (!en) begin
                mq.delete();
            end else begin
                void'(mq.pop_front());
                if (mq.size() == 0 && int'(divider) >= 2) push_period(int'(divider));
            end
        end else if (en && int'(divider) >= 2) begin
            push_period(int'(divider));
        end
        #1;
        model_outputs();
    endtask

    task automatic go_idle();
        en = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; divider = 16'd0;
        #3;
        tests++;
        if ({square, active, period_end} !== 3'b000) begin
            fails++;
            $display("FAIL reset_idle got %b%b%b want 000", square, active, period_end);
        end
        en = 1'b1; divider = 16'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({square, active, period_end} !== 3'b000) begin
                fails++;
                $display("FAIL reset_hold i=%0d got %b%b%b want 000", i, square, active,
                         period_end);
            end
        end
        en = 1'b0;
        rst = 1'b0;
        tick();
        tests++;
        if (active !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_en0 active=%b want 0", active);
        end
    endtask

    task automatic test_div4();
        go_idle();
        en = 1'b1; divider = 16'd4;
        for (int i = 0; i < 12; i++) begin
            tick();
            tests++;
            if (square !== ((i % 4) < 2) || period_end !== ((i % 4) == 3) || active !== 1'b1)
            begin
                fails++;
                $display("FAIL div4 i=%0d got sq=%b pe=%b act=%b want sq=%b pe=%b act=1", i,
                         square, period_end, active, (i % 4) < 2, (i % 4) == 3);
            end
        end
    endtask

    task automatic test_div5();
        go_idle();
        en = 1'b1; divider = 16'd5;
        for (int i = 0; i < 15; i++) begin
            tick();
            tests++;
            if (square !== ((i % 5) < 2) || period_end !== ((i % 5) == 4) || active !== 1'b1)
            begin
                fails++;
                $display("FAIL div5 i=%0d got sq=%b pe=%b act=%b want sq=%b pe=%b act=1", i,
                         square, period_end, active, (i % 5) < 2, (i % 5) == 4);
            end
        end
    endtask

    task automatic test_div_change();
        logic esq, epe;
        go_idle();
        en = 1'b1; divider = 16'd4;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i < 4) begin
                esq = (i < 2); epe = (i == 3);
            end else begin
                esq = ((i - 4) % 6) < 3; epe = ((i - 4) % 6) == 5;
            end
            tests++;
            if (square !== esq || period_end !== epe || active !== 1'b1) begin
                fails++;
                $display("FAIL div_change i=%0d got sq=%b pe=%b act=%b want sq=%b pe=%b act=1",
                         i, square, period_end, active, esq, epe);
            end
            if (i == 1) divider = 16'd6;
        end
    endtask

    task automatic test_stop_div0();
        go_idle();
        en = 1'b1; divider = 16'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (square !== (i < 2) || active !== 1'b1) begin
                fails++;
                $display("FAIL stop_div0 run i=%0d got sq=%b act=%b want sq=%b act=1", i,
                         square, active, i < 2);
            end
            if (i == 2) divider = 16'd0;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if ({square, active, period_end} !== 3'b000) begin
                fails++;
                $display("FAIL stop_div0 idle i=%0d got %b%b%b want 000", i, square, active,
                         period_end);
            end
        end
    endtask

    task automatic test_div1();
        go_idle();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            divider = (i < 4) ? 16'd1 : 16'd0;
            tick();
            tests++;
            if (active !== 1'b0 || square !== 1'b0) begin
                fails++;
                $display("FAIL div_lt2 i=%0d got act=%b sq=%b want 0 0", i, active, square);
            end
        end
    endtask

    task automatic test_en_drop();
        go_idle();
        en = 1'b1; divider = 16'd38223;
        for (int i = 0; i <= 100; i++) tick();
        tests++;
        if (square !== 1'b1 || active !== 1'b1) begin
            fails++;
            $display("FAIL en_drop count100 got sq=%b act=%b want 1 1", square, active);
        end
        en = 1'b0;
        tick();
        tests++;
        if (active !== 1'b0 || square !== 1'b0) begin
            fails++;
            $display("FAIL en_drop muted got act=%b sq=%b want 0 0", active, square);
        end
        // Re-enable on the very next cycle with a new divider: a fresh period of 3 starts.
        en = 1'b1; divider = 16'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (square !== ((i % 3) < 1) || period_end !== ((i % 3) == 2) || active !== 1'b1)
            begin
                fails++;
                $display("FAIL en_restart i=%0d got sq=%b pe=%b act=%b want sq=%b pe=%b act=1",
                         i, square, period_end, active, (i % 3) < 1, (i % 3) == 2);
            end
        end
    endtask

    task automatic test_async_reset();
        go_idle();
        en = 1'b1; divider = 16'd8;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        tests++;
        if ({square, active, period_end} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset got %b%b%b want 000", square, active, period_end);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (square !== (i < 4) || period_end !== (i == 7) || active !== 1'b1) begin
                fails++;
                $display("FAIL post_reset i=%0d got sq=%b pe=%b act=%b want sq=%b pe=%b act=1",
                         i, square, period_end, active, i < 4, i == 7);
            end
        end
    endtask

    task automatic test_max_div();
        go_idle();
        en = 1'b1; divider = 16'hffff;
        for (int i = 0; i <= 65535; i++) begin
            tick();
            if (i == 0 || i == 32766 || i == 32767 || i == 65534 || i == 65535) begin
                tests++;
                if (square !== (i < 32767 || i == 65535) || period_end !== (i == 65534) ||
                    active !== 1'b1) begin
                    fails++;
                    $display("FAIL max_div i=%0d got sq=%b pe=%b act=%b", i, square,
                             period_end, active);
                end
            end
        end
    endtask

    task automatic test_random();
        go_idle();
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 4) == 0) divider = 16'($urandom_range(0, 9));
            tick();
            tests++;
            if ({square, active, period_end} !== {m_sq, m_act, m_pe}) begin
                fails++;
                $display("FAIL random i=%0d en=%b div=%0d got %b%b%b want %b%b%b", i, en,
                         divider, square, active, period_end, m_sq, m_act, m_pe);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_div5();
        test_div_change();
        test_stop_div0();
        test_div1();
        test_en_drop();
        test_async_reset();
        test_random();
        test_max_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/oscillator.md
OSCILLATOR -- requirements
Module: oscillator

Interface
REQ-001 The module SHALL have one parameter: DIV_W, default 16, the width of the divider and internal period counter.
REQ-002 clk  input  1  system clock; all state is updated on the rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 en  input  1  tone enable; 0 mutes immediately.
REQ-005 divider  input  DIV_W  requested full-period length in clk cycles; 0 and 1 mean silence.
REQ-006 square  output  1  square-wave tone output.
REQ-007 active  output  1  high while a tone is being generated.
REQ-008 period_end  output  1  one-cycle strobe on the last cycle of each tone period.

Function
REQ-009 The module SHALL hold three registers: state (IDLE/RUN), cur_div (DIV_W bits) and count (DIV_W bits).
REQ-010 All outputs SHALL be decoded from registers only, with no combinational path from en or divider.
- active = (state==RUN)
- square = active && (count < cur_div>>1)
- period_end = active && (count == cur_div-1)
REQ-011 In IDLE, when en=1 and divider>=2, the block SHALL load cur_div<=divider and count<=0, and enter RUN; otherwise it SHALL remain in IDLE with count=0.
REQ-012 In RUN with en=1, when count!=cur_div-1, count SHALL increment by 1.
REQ-013 In RUN with en=1, when count==cur_div-1 (boundary), count SHALL wrap to 0 and the block SHALL resample divider.
- divider>=2: cur_div<=divider and stay in RUN.
- divider<2: go to IDLE.
REQ-014 Changes on divider in the middle of a period SHALL be ignored until the next boundary, so every emitted period is complete and glitch-free.
REQ-015 Each period SHALL last exactly cur_div cycles.
- High phase: floor(cur_div/2) cycles.
- Low phase: ceil(cur_div/2) cycles.
- Odd dividers therefore have one extra low cycle.
REQ-016 In RUN, en=0 SHALL force IDLE on the next edge regardless of count, with count<=0.
REQ-017 The first cycle in RUN SHALL have count=0 and square=1.
- Latency from the edge that samples en&&divider>=2 to square=1 is one clock.
REQ-018 When en falls and rises on consecutive cycles, the block SHALL restart a fresh period from count=0 with the newly sampled divider.
REQ-019 The count comparison SHALL be full DIV_W-bit unsigned; divider=2^DIV_W-1 SHALL be supported without overflow.
REQ-020 cur_div SHALL never hold a value below 2 while in RUN.

Reset
REQ-021 While rst=1 the block SHALL asynchronously force state=IDLE, count=0 and cur_div=0, giving square=0, active=0 and period_end=0.
REQ-022 After rst is released, the first tone SHALL start only through the IDLE entry condition of REQ-011.
REQ-023 Reset asserted mid-period SHALL abort the tone immediately, with no completion of the current period.

Verification
REQ-024 en=1, divider=4 held: square SHALL follow 1,1,0,0 repeating starting one cycle after sampling, with period_end high on every 4th RUN cycle.
REQ-025 en=1, divider=5: square SHALL follow 1,1,0,0,0 repeating, with period_end on count=4.
REQ-026 Start with divider=4; at count=1 change divider to 6: the current period SHALL finish as 1,1,0,0, then 1,1,1,0,0,0 SHALL repeat.
REQ-027 Start with divider=4; set divider=0 at count=2 with en=1 held: the block SHALL finish count 2,3, then return to IDLE with square=0 and active=0.
- Also check divider=1 with en=1 from IDLE: active SHALL never assert.
REQ-028 Start with divider=38223; drop en at count=100: the next cycle SHALL have active=0 and square=0.
- Re-raise en: square SHALL be 1 one cycle later with count=0.
REQ-029 Assert rst asynchronously mid-high-phase with divider=8: square and active SHALL go to 0 immediately.
- After release, with en=1, a fresh 8-cycle period SHALL begin one clock later.
